alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
Execute stage directly downstream of the register file. Takes the two read operands (rdata_A/rdata_B) with an opcode and destination address, and computes a registered result. It drives the register file write port (we, reg_Wt_addr, wdata) with the result. Single-cycle logic/arithmetic ops complete in 1 cycle; multiply is iterative shift-add over WIDTH cycles with a valid/ready handshake on the issue side.

Parameters:
WIDTH, 32, operand/result width
ADDR_W, 5, register address width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  one clock; reset is asynchronous and active-low
in_valid  input  1  issue request; operands/op/address valid this cycle
in_ready  output  1  stage can accept an issue this cycle
alu_op  input  4  operation select
op_A  input  WIDTH  operand A (from rdata_A)
op_B  input  WIDTH  operand B (from rdata_B)
dst_addr  input  ADDR_W  destination register address
wb_we  output  1  register file write enable, one-cycle pulse per result
wb_addr  output  ADDR_W  register file write address
wb_data  output  WIDTH  result data
zero  output  1  last result == 0
overflow  output  1  signed overflow of last ADD/SUB
busy  output  1  multiply in progress

Behaviour:
- Reset (rst=0, async): state IDLE; wb_we=0, wb_addr=0, wb_data=0, zero=0, overflow=0, busy=0, in_ready=0 while asserted; internal counter/accumulators cleared.
- in_ready = 1 in IDLE (after reset release) and in DONE; 0 in MUL. Issue accepted on rising edge when in_valid && in_ready; inputs are sampled only then.
- Opcodes: 0 AND; 1 OR; 2 ADD; 3 XOR; 4 NOR; 5 SRL (op_B >> op_A[4:0], logical); 6 SUB (A-B); 7 SLT signed (result 1/0); 8 MUL (low WIDTH bits of A*B, unsigned); 9-15 undefined -> result 0, written normally.
- Arithmetic is modulo 2^WIDTH. overflow=1 only for ADD/SUB when signed overflow occurs (ADD: operand signs equal and result sign differs; SUB: operand signs differ and result sign differs from A); 0 for all other ops.
- Single-cycle ops (0-7, 9-15): issue at edge N -> wb_data/wb_addr/zero/overflow updated and wb_we=1 at edge N (visible cycle N+1); wb_we returns to 0 next edge unless another issue is accepted. Back-to-back issues every cycle are supported.
- FSM: IDLE -> (issue op 8) MUL; IDLE -> (issue other) IDLE with result registered. MUL: latch A (multiplicand, shifted left each cycle), B (multiplier, shifted right), acc=0, cnt=0; each cycle, if B[0] then acc += A; cnt++. After WIDTH iterations (cnt==WIDTH-1 processed) -> DONE with wb_data=acc, wb_we=1, zero updated, overflow=0. DONE behaves as IDLE (accepts issue same cycle) and returns to IDLE if no issue.
- MUL latency: issue edge N -> wb_we pulse visible cycle N+WIDTH+1. busy=1 throughout MUL state only.
- dst_addr==0: result is computed and flags update, but wb_we is forced 0 (r0 is hardwired zero).
- in_valid while in_ready=0: ignored, not queued; upstream must hold.
- Reset mid-multiply: aborts immediately; no write pulse is produced; IDLE after release.
- zero/overflow hold their value until the next result is produced.

Test Plan:
- Reset: rst=0 for 50 ns mid-run -> all outputs 0, in_ready=0; after release in_ready=1 next cycle.
- ADD overflow: A=32'h7FFFFFFF, B=1, op=2, dst=5 -> next cycle wb_we=1, wb_addr=5, wb_data=32'h80000000, overflow=1, zero=0.
- SUB/SLT back-to-back: op=6 A=B=32'hA5A5A5A5 dst=6, then op=7 A=32'hFFFFFFFF B=1 dst=7 -> cycle1 wb_data=0, zero=1; cycle2 wb_data=1, wb_addr=7; wb_we high both cycles.
- MUL: A=32'h0000FFFF, B=32'h00010001, op=8, dst=9 -> busy=1, in_ready=0 for 32 cycles; wb_we single pulse at issue+33 with wb_data=32'hFFFFFFFF; in_valid held during MUL is not accepted until DONE.
- dst=0 write: op=1 A=32'hAAAA5555 B=0 dst=0 -> wb_we stays 0, wb_data=32'hAAAA5555, zero=0.
- Reset mid-MUL: assert rst at iteration 10 -> no wb_we pulse, busy=0, IDLE after release; a subsequent AND completes normally.

Source files
------------

// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
//   Execute stage sitting right after the register file. Single-cycle
//   logic/arithmetic ops produce a registered result one edge after issue;
//   MUL is an iterative shift-add taking WIDTH cycles, during which the
//   issue side is back-pressured through in_ready.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-low reset
//   in_valid  in   issue request (op/operands/address valid)
//   in_ready  out  stage accepts an issue this cycle
//   alu_op    in   operation select (0 AND,1 OR,2 ADD,3 XOR,4 NOR,5 SRL,
//                  6 SUB,7 SLT,8 MUL, others -> result 0)
//   op_A/op_B in   operands from the register file read ports
//   dst_addr  in   destination register
//   wb_we     out  register-file write enable, one pulse per result
//   wb_addr   out  register-file write address
//   wb_data   out  result data
//   zero      out  last result was zero
//   overflow  out  signed overflow of last result (ADD/SUB only)
//   busy      out  multiply in progress
// -----------------------------------------------------------------------------
module alu_exec_stage #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_op,
  input  logic [WIDTH-1:0]  op_A,
  input  logic [WIDTH-1:0]  op_B,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [WIDTH-1:0]  wb_data,
  output logic              zero,
  output logic              overflow,
  output logic              busy
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [3:0]       OP_MUL   = 4'd8;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t              state_q, state_d;
  logic                run_q;
  logic [WIDTH-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   mdst_q, mdst_d;
  logic                wb_we_q, wb_we_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [WIDTH-1:0]    wb_data_q, wb_data_d;
  logic                zero_q, zero_d;
  logic                ovf_q, ovf_d;

  logic [WIDTH-1:0]    alu_res;
  logic                alu_ovf;
  logic [WIDTH-1:0]    acc_next;
  logic                issue;

  function automatic logic [WIDTH-1:0] alu_result(input logic [3:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    sa = a;
    sb = b;
    case (op)
      4'd0:    alu_result = a & b;
      4'd1:    alu_result = a | b;
      4'd2:    alu_result = a + b;
      4'd3:    alu_result = a ^ b;
      4'd4:    alu_result = ~(a | b);
      4'd5:    alu_result = b >> a[SH_W-1:0];
      4'd6:    alu_result = a - b;
      4'd7:    alu_result = {{(WIDTH-1){1'b0}}, (sa < sb)};
      default: alu_result = '0;
    endcase
  endfunction

  // Sign-bit overflow rule: ADD overflows when like-signed operands give a
  // result of the other sign; SUB when unlike-signed operands give a result
  // whose sign differs from A.
  function automatic logic add_sub_ovf(input logic [3:0]       op,
                                       input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    logic             flag;
    flag = 1'b0;
    if (op == 4'd2) begin
      r    = a + b;
      flag = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end else if (op == 4'd6) begin
      r    = a - b;
      flag = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end
    return flag;
  endfunction

  assign alu_res  = alu_result(alu_op, op_A, op_B);
  assign alu_ovf  = add_sub_ovf(alu_op, op_A, op_B);
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  // run_q keeps in_ready low while reset is held and for the release cycle.
  assign in_ready = run_q && (state_q != MUL);
  assign issue    = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    mdst_d    = mdst_q;
    wb_we_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;

    case (state_q)
      MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d   = DONE;
          wb_data_d = acc_next;
          wb_addr_d = mdst_q;
          wb_we_d   = (mdst_q != '0);
          zero_d    = (acc_next == '0);
          ovf_d     = 1'b0;
        end
      end
      default: begin
        // IDLE and DONE behave identically: both accept a new issue.
        state_d = IDLE;
        if (issue) begin
          if (alu_op == OP_MUL) begin
            state_d  = MUL;
            mcand_d  = op_A;
            mplier_d = op_B;
            acc_d    = '0;
            cnt_d    = '0;
            mdst_d   = dst_addr;
          end else begin
            wb_data_d = alu_res;
            wb_addr_d = dst_addr;
            wb_we_d   = (dst_addr != '0);  // r0 is hardwired zero
            zero_d    = (alu_res == '0);
            ovf_d     = alu_ovf;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      run_q     <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      mdst_q    <= '0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      mdst_q    <= mdst_d;
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
    end
  end

  assign wb_we    = wb_we_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;
  assign busy     = (state_q == MUL);

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        alu_op;
  logic [WIDTH-1:0]  op_A;
  logic [WIDTH-1:0]  op_B;
  logic [ADDR_W-1:0] dst_addr;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [WIDTH-1:0]  wb_data;
  logic              zero;
  logic              overflow;
  logic              busy;

  alu_exec_stage #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_op   (alu_op),
    .op_A     (op_A),
    .op_B     (op_B),
    .dst_addr (dst_addr),
    .wb_we    (wb_we),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .zero     (zero),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: what the outputs must show after the next edge.
  logic              e_we, e_zero, e_ovf, alive;
  logic [ADDR_W-1:0] e_addr, m_dst;
  logic [WIDTH-1:0]  e_data, m_res;
  int                mul_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  // Spec-level ALU: plain arithmetic, overflow from the mathematically exact
  // signed result falling outside the 32-bit range.
  task automatic ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic ovf);
    longint sa, sb, exact;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    exact = 0;
    ovf   = 1'b0;
    case (op)
      4'd0: res = a & b;
      4'd1: res = a | b;
      4'd2: begin res = a + b; exact = sa + sb; end
      4'd3: res = a ^ b;
      4'd4: res = ~(a | b);
      4'd5: res = b >> a[4:0];
      4'd6: begin res = a - b; exact = sa - sb; end
      4'd7: res = (sa < sb) ? 32'd1 : 32'd0;
      default: res = 32'd0;
    endcase
    if (op == 4'd2 || op == 4'd6)
      ovf = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
  endtask

  task automatic model_reset();
    e_we = 0; e_addr = '0; e_data = '0; e_zero = 0; e_ovf = 0;
    mul_cnt = 0; alive = 0; m_res = '0; m_dst = '0;
  endtask

  task automatic set_result(input logic [31:0] res, input logic [ADDR_W-1:0] d, input logic ovf);
    e_data = res; e_addr = d; e_we = (d != '0); e_zero = (res == 32'd0); e_ovf = ovf;
  endtask

  task automatic model_edge(input bit v, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [ADDR_W-1:0] d);
    logic [63:0] prod;
    logic [31:0] res;
    logic        ovf;
    if (!rst) begin
      model_reset();
    end else begin
      e_we = 0;
      if (mul_cnt > 0) begin
        mul_cnt--;
        if (mul_cnt == 0) set_result(m_res, m_dst, 1'b0);
      end else if (v && alive) begin
        if (op == 4'd8) begin
          prod    = {32'd0, a} * {32'd0, b};
          m_res   = prod[31:0];
          m_dst   = d;
          mul_cnt = WIDTH;
        end else begin
          ref_alu(op, a, b, res, ovf);
          set_result(res, d, ovf);
        end
      end
      alive = 1;
    end
  endtask

  task automatic compare_outputs();
    check("wb_we",    32'(wb_we),    32'(e_we));
    check("wb_addr",  32'(wb_addr),  32'(e_addr));
    check("wb_data",  wb_data,       e_data);
    check("zero",     32'(zero),     32'(e_zero));
    check("overflow", 32'(overflow), 32'(e_ovf));
    check("busy",     32'(busy),     32'(mul_cnt > 0));
    check("in_ready", 32'(in_ready), 32'(alive && mul_cnt == 0));
  endtask

  // Called at a falling edge: check, drive, advance model, go to next falling edge.
  task automatic step(input bit v, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [ADDR_W-1:0] d);
    compare_outputs();
    in_valid = v; alu_op = op; op_A = a; op_B = b; dst_addr = d;
    model_edge(v, op, a, b, d);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 32'd0, '0);
  endtask

  task automatic assert_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_we",    32'(wb_we),    32'd0);
    check("rst_data",  wb_data,       32'd0);
    check("rst_busy",  32'(busy),     32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    rst = 1'b0; in_valid = 0; alu_op = '0; op_A = '0; op_B = '0; dst_addr = '0;
    model_reset();
    @(negedge clk);
    check("por_ready", 32'(in_ready), 32'd0);
    idle(3);
    rst = 1'b1;
    idle(2);
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // ADD signed overflow
    step(1'b1, 4'd2, 32'h7FFF_FFFF, 32'd1, 5'd5);
    check("add_data", wb_data, 32'h8000_0000);
    check("add_ovf",  32'(overflow), 32'd1);
    check("add_addr", 32'(wb_addr), 32'd5);
    idle(1);

    // SUB then SLT back to back
    step(1'b1, 4'd6, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 5'd6);
    check("sub_zero", 32'(zero), 32'd1);
    step(1'b1, 4'd7, 32'hFFFF_FFFF, 32'd1, 5'd7);
    check("slt_data", wb_data, 32'd1);
    check("slt_we",   32'(wb_we), 32'd1);
    idle(2);

    // MUL with an OR request held throughout; accepted only once in DONE
    step(1'b1, 4'd8, 32'h0000_FFFF, 32'h0001_0001, 5'd9);
    for (int i = 0; i < WIDTH; i++) step(1'b1, 4'd1, 32'h0000_00F0, 32'h0000_000F, 5'd10);
    check("mul_we",   32'(wb_we), 32'd1);
    check("mul_data", wb_data, 32'hFFFF_FFFF);
    step(1'b1, 4'd1, 32'h0000_00F0, 32'h0000_000F, 5'd10);
    check("held_or_data", wb_data, 32'h0000_00FF);
    idle(2);

    // Write to r0 suppressed, flags still update
    step(1'b1, 4'd1, 32'hAAAA_5555, 32'd0, 5'd0);
    check("r0_we",   32'(wb_we), 32'd0);
    check("r0_data", wb_data, 32'hAAAA_5555);
    idle(2);

    // Reset during multiply
    step(1'b1, 4'd8, 32'h1234_5678, 32'h9ABC_DEF1, 5'd12);
    idle(10);
    assert_reset();
    idle(5);
    rst = 1'b1;
    idle(WIDTH + 4);
    step(1'b1, 4'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd3);
    check("and_after_rst", wb_data, 32'h00F0_1234);
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)), rand_opnd(), rand_opnd(),
           ADDR_W'($urandom_range(0, 31)));
    end
    idle(WIDTH + 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
